// File: rtl/gpr_wb_arbiter.sv
// Round-robin arbiter for the GPR SRAM write port, with a per-register busy scoreboard for RAW stalls.
// Build option: define ZERO_REG_EN to hardwire register 0 to zero (never written, never busy).
module gpr_wb_arbiter #(
   parameter  int BUS_WIDTH = 8,
   parameter  int DEPTH     = 8,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [1:0]           wb_valid_i,
   output logic [1:0]           wb_ready_o,
   input  logic [AW-1:0]        wb_addr0_i,
   input  logic [AW-1:0]        wb_addr1_i,
   input  logic [BUS_WIDTH-1:0] wb_data0_i,
   input  logic [BUS_WIDTH-1:0] wb_data1_i,
   input  logic                 issue_valid_i,
   input  logic [AW-1:0]        issue_addr_i,
   input  logic [AW-1:0]        rs_a_i,
   input  logic [AW-1:0]        rs_b_i,
   output logic                 stall_o,
   output logic [DEPTH-1:0]     busy_o,
   output logic                 we_o,
   output logic [AW-1:0]        wr_addr_o,
   output logic [BUS_WIDTH-1:0] wr_data_o
);

`ifdef ZERO_REG_EN
   localparam bit ZERO_REG = 1'b1;
`else
   localparam bit ZERO_REG = 1'b0;
`endif

   typedef struct packed {
      logic [AW-1:0]        addr;
      logic [BUS_WIDTH-1:0] data;
   } wb_req_t;

   logic                 last_grant_q, last_grant_d;
   logic [DEPTH-1:0]     busy_q, busy_d;
   logic                 we_q, we_d;
   logic [AW-1:0]        wr_addr_q, wr_addr_d;
   logic [BUS_WIDTH-1:0] wr_data_q, wr_data_d;

   logic    acc;
   logic    wr_en;
   wb_req_t req [2];
   wb_req_t win;

   assign req[0] = '{addr: wb_addr0_i, data: wb_data0_i};
   assign req[1] = '{addr: wb_addr1_i, data: wb_data1_i};

   // On contention the port that did not win last time gets the grant.
   always_comb begin
      wb_ready_o = 2'b00;
      if (!rst_i) begin
         unique case (wb_valid_i)
            2'b01:   wb_ready_o = 2'b01;
            2'b10:   wb_ready_o = 2'b10;
            2'b11:   wb_ready_o = last_grant_q ? 2'b01 : 2'b10;
            default: wb_ready_o = 2'b00;
         endcase
      end
   end

   assign acc          = |wb_ready_o;
   assign win          = wb_ready_o[1] ? req[1] : req[0];
   assign last_grant_d = acc ? wb_ready_o[1] : last_grant_q;

   // A handshake to register 0 in the zero-register build is consumed but never written.
   assign wr_en     = acc & ~(ZERO_REG & (win.addr == '0));
   assign we_d      = wr_en;
   assign wr_addr_d = wr_en ? win.addr : wr_addr_q;
   assign wr_data_d = wr_en ? win.data : wr_data_q;

   // Set beats clear so a newer producer issued this cycle stays outstanding.
   for (genvar i = 0; i < DEPTH; i++) begin : g_busy
      logic set, clr;
      assign set       = issue_valid_i & (issue_addr_i == AW'(i));
      assign clr       = acc & (win.addr == AW'(i));
      assign busy_d[i] = (ZERO_REG && i == 0) ? 1'b0 : (set | (busy_q[i] & ~clr));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         last_grant_q <= 1'b1;
         busy_q       <= '0;
         we_q         <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         busy_q       <= busy_d;
         we_q         <= we_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
      end
   end

   // No same-cycle forwarding of the clear: a consumer is released the cycle after the write.
   assign stall_o   = busy_q[rs_a_i] | busy_q[rs_b_i];
   assign busy_o    = busy_q;
   assign we_o      = we_q;
   assign wr_addr_o = wr_addr_q;
   assign wr_data_o = wr_data_q;

endmodule
